// File: rtl/fm_frag_tx.sv
// Base-to-fragment packer with a ping-pong buffer of sealed fragments feeding the Extender.
// Define FM_FRAG_TX_PARITY_EN to add the frag_parity output (even parity of frag_data).
module fm_frag_tx #(
  parameter int BASE_LEN  = 2,
  parameter int FRAG_LEN  = 8,
  parameter int BUF_FRAGS = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [BASE_LEN-1:0]          in_base,
  input  logic                         in_last,
  output logic                         in_ready,
  output logic                         frag_valid,
  output logic [BASE_LEN*FRAG_LEN-1:0] frag_data,
  output logic                         frag_last,
`ifdef FM_FRAG_TX_PARITY_EN
  output logic                         frag_parity,
`endif
  input  logic                         frag_ready
);

  localparam int FW = BASE_LEN * FRAG_LEN;
  localparam int AW = (FRAG_LEN > 1) ? $clog2(FRAG_LEN) : 1;
  localparam int IW = (BUF_FRAGS > 1) ? $clog2(BUF_FRAGS) : 1;
  localparam logic [AW-1:0] ASM_LAST = AW'(FRAG_LEN - 1);
  localparam logic [IW-1:0] BUF_LAST = IW'(BUF_FRAGS - 1);

  typedef enum logic [1:0] {FREE, FILLING, SEALED, DRAINING} buf_state_t;

  buf_state_t st     [2];
  buf_state_t st_nxt [2];

  logic [FW-1:0] asm_data;
  logic [FW-1:0] frag_asm;
  logic [AW-1:0] asm_cnt;
  logic          wr_buf;
  logic          rd_buf;
  logic [IW-1:0] wr_cnt;
  logic [IW-1:0] rd_cnt;
  logic [IW-1:0] last_idx [2];
  logic [FW-1:0] mem_data [2][BUF_FRAGS];
  logic          mem_last [2][BUF_FRAGS];

  logic accept, commit, seal, pop, rd_final;

  assign in_ready   = !rst && (st[wr_buf] == FREE || st[wr_buf] == FILLING);
  assign frag_valid = (st[rd_buf] == SEALED) || (st[rd_buf] == DRAINING);
  assign frag_data  = frag_valid ? mem_data[rd_buf][rd_cnt] : '0;
  assign frag_last  = frag_valid && mem_last[rd_buf][rd_cnt];
`ifdef FM_FRAG_TX_PARITY_EN
  assign frag_parity = ^frag_data;
`endif

  assign accept   = in_valid && in_ready;
  assign commit   = accept && (asm_cnt == ASM_LAST || in_last);
  assign seal     = commit && (wr_cnt == BUF_LAST || in_last);
  assign pop      = frag_valid && frag_ready;
  assign rd_final = pop && (rd_cnt == last_idx[rd_buf]);

  // Fragment as it would look with the offered base dropped into its slot.
  always_comb begin
    frag_asm = asm_data;
    for (int k = 0; k < FRAG_LEN; k++) begin
      if (asm_cnt == AW'(k)) frag_asm[k*BASE_LEN +: BASE_LEN] = in_base;
    end
  end

  // Writer and reader never own the same buffer, so a seal and a free can coexist.
  always_comb begin
    st_nxt[0] = st[0];
    st_nxt[1] = st[1];
    for (int b = 0; b < 2; b++) begin
      if (accept && wr_buf == 1'(b)) st_nxt[b] = seal ? SEALED : FILLING;
      if (pop && rd_buf == 1'(b))    st_nxt[b] = rd_final ? FREE : DRAINING;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st[0] <= FREE;
      st[1] <= FREE;
    end else begin
      st[0] <= st_nxt[0];
      st[1] <= st_nxt[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asm_data    <= '0;
      asm_cnt     <= '0;
      wr_buf      <= 1'b0;
      wr_cnt      <= '0;
      rd_buf      <= 1'b0;
      rd_cnt      <= '0;
      last_idx[0] <= '0;
      last_idx[1] <= '0;
    end else begin
      if (commit) begin
        asm_data         <= '0;
        asm_cnt          <= '0;
        last_idx[wr_buf] <= wr_cnt;
        if (seal) begin
          wr_buf <= ~wr_buf;
          wr_cnt <= '0;
        end else begin
          wr_cnt <= wr_cnt + 1'b1;
        end
      end else if (accept) begin
        asm_data <= frag_asm;
        asm_cnt  <= asm_cnt + 1'b1;
      end
      if (pop) begin
        if (rd_final) begin
          rd_buf <= ~rd_buf;
          rd_cnt <= '0;
        end else begin
          rd_cnt <= rd_cnt + 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: frag_data/frag_last are masked until a buffer is sealed.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem_data[wr_buf][wr_cnt] <= frag_asm;
      mem_last[wr_buf][wr_cnt] <= in_last;
    end
  end

endmodule

// File: tb/tb_fm_frag_tx.sv
// Randomized self-checking bench for fm_frag_tx against a packet-level fragment model.
// Parity checks are included when FM_FRAG_TX_PARITY_EN is defined.
module tb_fm_frag_tx;

  localparam int BL = 2;
  localparam int FL = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [1:0]  in_base;
  logic        in_last;
  logic        in_ready;
  logic        frag_valid;
  logic [15:0] frag_data;
  logic        frag_last;
  logic        frag_ready;
`ifdef FM_FRAG_TX_PARITY_EN
  logic        frag_parity;
`endif

  int n_cmp = 0;
  int n_err = 0;

  int          bq[$];
  bit          lq[$];
  logic [15:0] eq_data[$];
  bit          eq_last[$];

  fm_frag_tx #(.BASE_LEN(BL), .FRAG_LEN(FL), .BUF_FRAGS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_base    (in_base),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .frag_valid (frag_valid),
    .frag_data  (frag_data),
    .frag_last  (frag_last),
`ifdef FM_FRAG_TX_PARITY_EN
    .frag_parity(frag_parity),
`endif
    .frag_ready (frag_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_base(input int b, input bit l);
    bq.push_back(b);
    lq.push_back(l);
  endtask

  task automatic push_exp(input logic [15:0] d, input bit l);
    eq_data.push_back(d);
    eq_last.push_back(l);
  endtask

  // Model: fragment f holds bases f*FL .. f*FL+FL-1, base k weighted by 2^(BL*k).
  task automatic add_pkt(input int n, input bit with_last);
    int pkt[$];
    int nf;
    int idx;
    logic [31:0] val;
    for (int i = 0; i < n; i++) pkt.push_back(int'($urandom_range(3)));
    for (int i = 0; i < n; i++) push_base(pkt[i], with_last && (i == n - 1));
    nf = (n + FL - 1) / FL;
    for (int f = 0; f < nf; f++) begin
      val = 0;
      for (int k = 0; k < FL; k++) begin
        idx = f * FL + k;
        if (idx < n) val = val + (32'(pkt[idx]) << (BL * k));
      end
      push_exp(val[15:0], with_last && (f == nf - 1));
    end
  endtask

  // Called at a negedge where frag_valid && frag_ready: the fragment transfers next edge.
  task automatic pop_chk();
    if (eq_data.size() == 0) begin
      chk("extra_frag", frag_data, 32'hDEAD);
    end else begin
      chk("frag_data", frag_data, eq_data[0]);
      chk("frag_last", frag_last, eq_last[0]);
`ifdef FM_FRAG_TX_PARITY_EN
      chk("frag_parity", frag_parity, ^eq_data[0]);
`endif
      void'(eq_data.pop_front());
      void'(eq_last.pop_front());
    end
  endtask

  // Drives all queued bases; with drain set also consumes expected fragments.
  task automatic run(input int vld_pct, input int rdy_pct, input bit drain);
    int          cyc = 0;
    bit          stall = 0;
    bit          done;
    logic [15:0] pd = '0;
    logic        pl = 1'b0;
    done = 0;
    while (!done && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        chk("stall_valid", frag_valid, 1);
        chk("stall_data", frag_data, pd);
        chk("stall_last", frag_last, pl);
      end
      in_valid   = (bq.size() > 0) && ($urandom_range(99) < vld_pct);
      in_base    = in_valid ? 2'(bq[0]) : 2'd0;
      in_last    = in_valid ? lq[0] : 1'b0;
      frag_ready = drain && ($urandom_range(99) < rdy_pct);
      if (in_valid && in_ready) begin
        void'(bq.pop_front());
        void'(lq.pop_front());
      end
      if (frag_valid && frag_ready) pop_chk();
      stall = frag_valid && !frag_ready;
      pd    = frag_data;
      pl    = frag_last;
      done  = (bq.size() == 0) && (!drain || eq_data.size() == 0);
    end
    chk("run_complete", done, 1);
    @(negedge clk);
    in_valid   = 1'b0;
    in_last    = 1'b0;
    frag_ready = 1'b0;
  endtask

  initial begin
    int  npop;
    int  cyc;
    bit  seen4;

    rst = 1'b1; in_valid = 0; in_base = 0; in_last = 0; frag_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_frag_valid", frag_valid, 0);
    chk("rst_frag_data", frag_data, 0);
    chk("rst_frag_last", frag_last, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", in_ready, 1);

    // 0,1,2,3,0,1,2,3 with last
    for (int i = 0; i < 8; i++) push_base(i % 4, i == 7);
    push_exp(16'hE4E4, 1);
    run(100, 100, 1);
    chk("idle_e4e4", frag_valid, 0);

    // 3,3,3 with last
    for (int i = 0; i < 3; i++) push_base(3, i == 2);
    push_exp(16'h003F, 1);
    run(60, 100, 1);
    chk("idle_3f", frag_valid, 0);

`ifdef FM_FRAG_TX_PARITY_EN
    push_base(1, 1); push_exp(16'h0001, 1);
    push_base(3, 1); push_exp(16'h0003, 1);
    run(100, 100, 1);
`endif

    // 64 bases, no last, Extender stalled: both buffers seal
    add_pkt(64, 0);
    run(100, 0, 0);
    chk("full_in_ready", in_ready, 0);
    chk("full_frag_valid", frag_valid, 1);
    frag_ready = 1'b1;
    npop = 0; cyc = 0; seen4 = 0;
    while (npop < 8 && cyc < 50) begin
      if (frag_valid) begin
        if (npop < 4) chk("ready_hold", in_ready, 0);
        pop_chk();
        npop++;
      end
      @(negedge clk);
      cyc++;
      if (npop == 4 && !seen4) begin
        chk("ready_after_free", in_ready, 1);
        seen4 = 1;
      end
    end
    frag_ready = 1'b0;
    chk("drain_cycles", cyc, 8);
    chk("drain_empty", frag_valid, 0);

    // 40-base packet under random backpressure
    add_pkt(40, 1);
    run(80, 50, 1);
    chk("idle_40", frag_valid, 0);

    // reset with a sealed buffer pending and 5 bases in the assembler
    for (int i = 0; i < 3; i++) push_base(3, i == 2);
    run(100, 0, 0);
    for (int i = 0; i < 5; i++) push_base(int'($urandom_range(1, 3)), 0);
    run(100, 0, 0);
    chk("pre_rst_valid", frag_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_frag_valid", frag_valid, 0);
    chk("mid_rst_frag_data", frag_data, 0);
    chk("mid_rst_frag_last", frag_last, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    add_pkt(11, 1);
    run(80, 70, 1);
    chk("idle_post_rst", frag_valid, 0);

    // random packet stream
    for (int p = 0; p < 6; p++) add_pkt(int'($urandom_range(1, 40)), 1);
    run(70, 60, 1);
    chk("idle_random", frag_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
